// File: rtl/pipeline_types.sv
// Types shared between the decode front end and the rename stage:
// the decoded control payload and physical-register tag sizing.
package pipeline_types;

   localparam int ARCH_REGS     = 32;
   localparam int AREG_W        = 5;
   localparam int NUM_PREGS_DEF = 64;
   localparam int PREG_W_DEF    = $clog2(NUM_PREGS_DEF);
   localparam int FL_DEPTH_DEF  = NUM_PREGS_DEF - ARCH_REGS;

   typedef logic [PREG_W_DEF-1:0] preg_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] imm;
      logic        alu_src;
      logic [3:0]  alu_op;
      logic        branch;
      logic        jump;
      logic        mem_read;
      logic        mem_write;
      logic        reg_write;
      logic        mem_to_reg;
   } dec_ctrl_t;

   // x0 is never renamed, so writes to it consume no tag.
   function automatic logic needs_alloc(input dec_ctrl_t ctrl, input logic [AREG_W-1:0] rd);
      return ctrl.reg_write && (rd != '0);
   endfunction

endpackage

// File: rtl/rename_free_list.sv
// Circular FIFO of free physical tags; resets holding every tag above the
// architectural range, in ascending order.
module rename_free_list
   import pipeline_types::*;
#(
   parameter  int NUM_PREGS = 64,
   localparam int PREG_W    = $clog2(NUM_PREGS),
   localparam int FL_DEPTH  = NUM_PREGS - ARCH_REGS,
   localparam int IDX_W     = $clog2(FL_DEPTH),
   localparam int CNT_W     = $clog2(FL_DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pop_i,
   input  logic              push_i,
   input  logic [PREG_W-1:0] push_preg_i,
   output logic [PREG_W-1:0] head_preg_o,
   output logic [CNT_W-1:0]  count_o
);

   logic [PREG_W-1:0] mem_q [FL_DEPTH];
   logic [PREG_W-1:0] mem_d [FL_DEPTH];
   logic [IDX_W-1:0]  head_q, head_d;
   logic [IDX_W-1:0]  tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              push_ok;
   logic              pop_ok;

   // Depth need not be a power of two for larger register files.
   function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
      return (idx == IDX_W'(FL_DEPTH - 1)) ? '0 : idx + IDX_W'(1);
   endfunction

   assign push_ok = push_i && (push_preg_i != '0) && (count_q != CNT_W'(FL_DEPTH));
   assign pop_ok  = pop_i && (count_q != '0);

   always_comb begin
      mem_d   = mem_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (push_ok) begin
         mem_d[tail_q] = push_preg_i;
         tail_d        = wrap_inc(tail_q);
      end
      if (pop_ok) begin
         head_d = wrap_inc(head_q);
      end
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < FL_DEPTH; i++) begin
            mem_q[i] <= PREG_W'(ARCH_REGS + i);
         end
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= CNT_W'(FL_DEPTH);
      end else begin
         mem_q   <= mem_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // A pushed tag only becomes visible here after the clock edge: no bypass.
   assign head_preg_o = mem_q[head_q];
   assign count_o     = count_q;

   a_push_nonzero: assert property (@(posedge clk) disable iff (reset)
      push_i |-> (push_preg_i != '0));
   a_push_not_full: assert property (@(posedge clk) disable iff (reset)
      push_i |-> (count_q != CNT_W'(FL_DEPTH)));

endmodule

// File: rtl/rename_stage.sv
// Single-issue rename: map-table lookup and destination allocation, with the
// renamed instruction held in a registered output slot toward dispatch.
module rename_stage
   import pipeline_types::*;
#(
   parameter  int NUM_PREGS = 64,
   localparam int PREG_W    = $clog2(NUM_PREGS),
   localparam int FL_DEPTH  = NUM_PREGS - ARCH_REGS,
   localparam int CNT_W     = $clog2(FL_DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fe_valid_i,
   output logic              fe_ready_o,
   input  logic [4:0]        fe_rs1_i,
   input  logic [4:0]        fe_rs2_i,
   input  logic [4:0]        fe_rd_i,
   input  dec_ctrl_t         fe_ctrl_i,
   output logic              ren_valid_o,
   input  logic              ren_ready_i,
   output logic [PREG_W-1:0] ren_ps1_o,
   output logic [PREG_W-1:0] ren_ps2_o,
   output logic [PREG_W-1:0] ren_pd_o,
   output logic [PREG_W-1:0] ren_old_pd_o,
   output dec_ctrl_t         ren_ctrl_o,
   input  logic              free_valid_i,
   input  logic [PREG_W-1:0] free_preg_i
);

   logic [PREG_W-1:0] map_q [ARCH_REGS];
   logic [PREG_W-1:0] map_d [ARCH_REGS];

   logic              ren_valid_q, ren_valid_d;
   logic [PREG_W-1:0] ren_ps1_q, ren_ps1_d;
   logic [PREG_W-1:0] ren_ps2_q, ren_ps2_d;
   logic [PREG_W-1:0] ren_pd_q, ren_pd_d;
   logic [PREG_W-1:0] ren_old_pd_q, ren_old_pd_d;
   dec_ctrl_t         ren_ctrl_q, ren_ctrl_d;

   logic [PREG_W-1:0] fl_head;
   logic [CNT_W-1:0]  fl_count;
   logic              accept;
   logic              alloc;

   // Stalls on an empty free list even when no tag is needed; keeps the
   // ready path independent of the incoming instruction.
   assign fe_ready_o = (!ren_valid_q || ren_ready_i) && (fl_count != '0);
   assign accept     = fe_valid_i && fe_ready_o;
   assign alloc      = needs_alloc(fe_ctrl_i, fe_rd_i);

   rename_free_list #(
      .NUM_PREGS (NUM_PREGS)
   ) u_free_list (
      .clk         (clk),
      .reset       (reset),
      .pop_i       (accept && alloc),
      .push_i      (free_valid_i),
      .push_preg_i (free_preg_i),
      .head_preg_o (fl_head),
      .count_o     (fl_count)
   );

   // Sources read the registered table, so rs == rd sees the prior mapping.
   always_comb begin
      map_d = map_q;
      if (accept && alloc) begin
         map_d[fe_rd_i] = fl_head;
      end
      map_d[0] = '0;
   end

   always_comb begin
      ren_valid_d  = ren_valid_q;
      ren_ps1_d    = ren_ps1_q;
      ren_ps2_d    = ren_ps2_q;
      ren_pd_d     = ren_pd_q;
      ren_old_pd_d = ren_old_pd_q;
      ren_ctrl_d   = ren_ctrl_q;
      if (accept) begin
         ren_valid_d  = 1'b1;
         ren_ps1_d    = map_q[fe_rs1_i];
         ren_ps2_d    = map_q[fe_rs2_i];
         ren_pd_d     = alloc ? fl_head : '0;
         ren_old_pd_d = map_q[fe_rd_i];
         ren_ctrl_d   = fe_ctrl_i;
      end else if (ren_ready_i) begin
         ren_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < ARCH_REGS; i++) begin
            map_q[i] <= PREG_W'(i);
         end
      end else begin
         map_q <= map_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ren_valid_q  <= 1'b0;
         ren_ps1_q    <= '0;
         ren_ps2_q    <= '0;
         ren_pd_q     <= '0;
         ren_old_pd_q <= '0;
         ren_ctrl_q   <= '0;
      end else begin
         ren_valid_q  <= ren_valid_d;
         ren_ps1_q    <= ren_ps1_d;
         ren_ps2_q    <= ren_ps2_d;
         ren_pd_q     <= ren_pd_d;
         ren_old_pd_q <= ren_old_pd_d;
         ren_ctrl_q   <= ren_ctrl_d;
      end
   end

   assign ren_valid_o  = ren_valid_q;
   assign ren_ps1_o    = ren_ps1_q;
   assign ren_ps2_o    = ren_ps2_q;
   assign ren_pd_o     = ren_pd_q;
   assign ren_old_pd_o = ren_old_pd_q;
   assign ren_ctrl_o   = ren_ctrl_q;

endmodule

// File: tb/tb_rename_stage.sv
// Scoreboarded bench for rename_stage: a reference map table and free list
// predict each renamed instruction, which is checked when dispatch takes it.
module tb_rename_stage;
   import pipeline_types::*;

   logic       clk;
   logic       reset;
   logic       fe_valid_i;
   logic       fe_ready_o;
   logic [4:0] fe_rs1_i, fe_rs2_i, fe_rd_i;
   dec_ctrl_t  fe_ctrl_i;
   logic       ren_valid_o;
   logic       ren_ready_i;
   logic [5:0] ren_ps1_o, ren_ps2_o, ren_pd_o, ren_old_pd_o;
   dec_ctrl_t  ren_ctrl_o;
   logic       free_valid_i;
   logic [5:0] free_preg_i;

   rename_stage #(.NUM_PREGS(64)) dut (
      .clk          (clk),
      .reset        (reset),
      .fe_valid_i   (fe_valid_i),
      .fe_ready_o   (fe_ready_o),
      .fe_rs1_i     (fe_rs1_i),
      .fe_rs2_i     (fe_rs2_i),
      .fe_rd_i      (fe_rd_i),
      .fe_ctrl_i    (fe_ctrl_i),
      .ren_valid_o  (ren_valid_o),
      .ren_ready_i  (ren_ready_i),
      .ren_ps1_o    (ren_ps1_o),
      .ren_ps2_o    (ren_ps2_o),
      .ren_pd_o     (ren_pd_o),
      .ren_old_pd_o (ren_old_pd_o),
      .ren_ctrl_o   (ren_ctrl_o),
      .free_valid_i (free_valid_i),
      .free_preg_i  (free_preg_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [5:0] ps1;
      logic [5:0] ps2;
      logic [5:0] pd;
      logic [5:0] old_pd;
      dec_ctrl_t  ctrl;
   } exp_t;

   exp_t sb[$];
   int   mmap[32];
   int   mfree[$];
   bit   mvalid;
   int   total = 0;
   int   bad   = 0;

   task automatic model_reset();
      for (int i = 0; i < 32; i++) mmap[i] = i;
      mfree.delete();
      for (int i = 32; i < 64; i++) mfree.push_back(i);
      mvalid = 1'b0;
      sb.delete();
   endtask

   task automatic drive(input int rs1, input int rs2, input int rd, input bit rw);
      dec_ctrl_t c;
      c            = '0;
      c.pc         = $urandom;
      c.imm        = $urandom;
      c.alu_op     = 4'($urandom_range(0, 15));
      c.alu_src    = 1'($urandom_range(0, 1));
      c.mem_write  = !rw;
      c.reg_write  = rw;
      fe_rs1_i     = 5'(rs1);
      fe_rs2_i     = 5'(rs2);
      fe_rd_i      = 5'(rd);
      fe_ctrl_i    = c;
      fe_valid_i   = 1'b1;
   endtask

   // One clock: predict, check at the falling edge, then advance the model.
   task automatic step();
      exp_t e;
      bit   exp_ready;
      int   nfree;
      @(negedge clk);
      nfree     = mfree.size();
      exp_ready = (!mvalid || ren_ready_i) && (nfree != 0);
      total++;
      if (fe_ready_o !== exp_ready) begin
         bad++;
         $display("FAIL fe_ready: got %0b expected %0b", fe_ready_o, exp_ready);
      end
      total++;
      if (ren_valid_o !== mvalid) begin
         bad++;
         $display("FAIL ren_valid: got %0b expected %0b", ren_valid_o, mvalid);
      end
      if (mvalid && sb.size() != 0) begin
         e = sb[0];
         total++;
         if (ren_ps1_o !== e.ps1 || ren_ps2_o !== e.ps2 || ren_pd_o !== e.pd ||
             ren_old_pd_o !== e.old_pd || ren_ctrl_o !== e.ctrl) begin
            bad++;
            $display("FAIL slot: got ps1=%0d ps2=%0d pd=%0d old=%0d ctrl=%h expected ps1=%0d ps2=%0d pd=%0d old=%0d ctrl=%h",
                     ren_ps1_o, ren_ps2_o, ren_pd_o, ren_old_pd_o, ren_ctrl_o,
                     e.ps1, e.ps2, e.pd, e.old_pd, e.ctrl);
         end
         if (ren_ready_i) begin
            void'(sb.pop_front());
            $display("txn: ps1=%0d ps2=%0d pd=%0d old_pd=%0d", e.ps1, e.ps2, e.pd, e.old_pd);
         end
      end
      if (fe_valid_i && exp_ready) begin
         e.ps1    = 6'(mmap[fe_rs1_i]);
         e.ps2    = 6'(mmap[fe_rs2_i]);
         e.old_pd = 6'(mmap[fe_rd_i]);
         e.ctrl   = fe_ctrl_i;
         if (fe_ctrl_i.reg_write && fe_rd_i != 0) begin
            e.pd = 6'(mfree.pop_front());
            mmap[fe_rd_i] = int'(e.pd);
         end else begin
            e.pd = '0;
         end
         sb.push_back(e);
         mvalid = 1'b1;
      end else if (ren_ready_i) begin
         mvalid = 1'b0;
      end
      if (free_valid_i && free_preg_i != 0 && nfree < 32) mfree.push_back(int'(free_preg_i));
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset        = 1'b1;
      fe_valid_i   = 1'b0;
      fe_rs1_i     = '0;
      fe_rs2_i     = '0;
      fe_rd_i      = '0;
      fe_ctrl_i    = '0;
      ren_ready_i  = 1'b1;
      free_valid_i = 1'b0;
      free_preg_i  = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      apply_reset();
      total++;
      if (ren_valid_o !== 1'b0 || fe_ready_o !== 1'b1) begin
         bad++;
         $display("FAIL reset_hs: got valid=%0b ready=%0b expected valid=0 ready=1", ren_valid_o, fe_ready_o);
      end
      total++;
      if (ren_ps1_o !== 6'd0 || ren_ps2_o !== 6'd0 || ren_pd_o !== 6'd0 || ren_old_pd_o !== 6'd0 || ren_ctrl_o !== '0) begin
         bad++;
         $display("FAIL reset_data: got ps1=%0d ps2=%0d pd=%0d old=%0d expected all 0",
                  ren_ps1_o, ren_ps2_o, ren_pd_o, ren_old_pd_o);
      end
   endtask

   task automatic test_first_and_dependent();
      drive(1, 2, 5, 1);
      step();
      total++;
      if (ren_valid_o !== 1'b1 || ren_ps1_o !== 6'd1 || ren_ps2_o !== 6'd2 ||
          ren_pd_o !== 6'd32 || ren_old_pd_o !== 6'd5) begin
         bad++;
         $display("FAIL add_x5: got v=%0b ps1=%0d ps2=%0d pd=%0d old=%0d expected v=1 ps1=1 ps2=2 pd=32 old=5",
                  ren_valid_o, ren_ps1_o, ren_ps2_o, ren_pd_o, ren_old_pd_o);
      end
      drive(5, 5, 6, 1);
      step();
      total++;
      if (ren_ps1_o !== 6'd32 || ren_ps2_o !== 6'd32 || ren_pd_o !== 6'd33 || ren_old_pd_o !== 6'd6) begin
         bad++;
         $display("FAIL add_x6: got ps1=%0d ps2=%0d pd=%0d old=%0d expected ps1=32 ps2=32 pd=33 old=6",
                  ren_ps1_o, ren_ps2_o, ren_pd_o, ren_old_pd_o);
      end
   endtask

   task automatic test_no_alloc();
      drive(6, 5, 7, 0);
      step();
      total++;
      if (ren_pd_o !== 6'd0 || ren_ps1_o !== 6'd33 || ren_old_pd_o !== 6'd7) begin
         bad++;
         $display("FAIL store: got pd=%0d ps1=%0d old=%0d expected pd=0 ps1=33 old=7", ren_pd_o, ren_ps1_o, ren_old_pd_o);
      end
      drive(1, 0, 0, 1);
      step();
      total++;
      if (ren_pd_o !== 6'd0 || ren_old_pd_o !== 6'd0) begin
         bad++;
         $display("FAIL addi_x0: got pd=%0d old=%0d expected pd=0 old=0", ren_pd_o, ren_old_pd_o);
      end
      drive(7, 0, 7, 1);
      step();
      total++;
      if (ren_pd_o !== 6'd34 || ren_ps1_o !== 6'd7) begin
         bad++;
         $display("FAIL after_noalloc: got pd=%0d ps1=%0d expected pd=34 ps1=7", ren_pd_o, ren_ps1_o);
      end
      fe_valid_i = 1'b0;
      step();
   endtask

   task automatic test_back_to_back_exhaust();
      apply_reset();
      for (int i = 0; i < 32; i++) begin
         drive(i % 31 + 1, (i + 3) % 32, i % 31 + 1, 1);
         step();
      end
      total++;
      if (fe_ready_o !== 1'b0) begin
         bad++;
         $display("FAIL empty_ready: got %0b expected 0", fe_ready_o);
      end
      drive(2, 3, 9, 1);
      free_valid_i = 1'b1;
      free_preg_i  = 6'd5;
      step();
      free_valid_i = 1'b0;
      free_preg_i  = '0;
      total++;
      if (fe_ready_o !== 1'b1) begin
         bad++;
         $display("FAIL push_ready: got %0b expected 1", fe_ready_o);
      end
      step();
      total++;
      if (ren_pd_o !== 6'd5 || ren_old_pd_o !== 6'd40) begin
         bad++;
         $display("FAIL pushed_tag: got pd=%0d old=%0d expected pd=5 old=40", ren_pd_o, ren_old_pd_o);
      end
      fe_valid_i = 1'b0;
      step();
   endtask

   task automatic test_stall();
      logic [5:0] hold_pd, hold_ps1;
      apply_reset();
      ren_ready_i = 1'b0;
      drive(3, 4, 4, 1);
      step();
      hold_pd  = ren_pd_o;
      hold_ps1 = ren_ps1_o;
      drive(4, 4, 4, 1);
      for (int i = 0; i < 3; i++) begin
         step();
         total++;
         if (ren_pd_o !== hold_pd || ren_ps1_o !== hold_ps1 || hold_pd !== 6'd32) begin
            bad++;
            $display("FAIL stall_hold: got pd=%0d ps1=%0d expected pd=32 ps1=3", ren_pd_o, ren_ps1_o);
         end
      end
      ren_ready_i = 1'b1;
      step();
      total++;
      if (ren_valid_o !== 1'b1 || ren_ps1_o !== 6'd32 || ren_pd_o !== 6'd33 || ren_old_pd_o !== 6'd32) begin
         bad++;
         $display("FAIL stall_release: got v=%0b ps1=%0d pd=%0d old=%0d expected v=1 ps1=32 pd=33 old=32",
                  ren_valid_o, ren_ps1_o, ren_pd_o, ren_old_pd_o);
      end
      fe_valid_i = 1'b0;
      step();
   endtask

   task automatic test_reset_mid();
      apply_reset();
      for (int i = 1; i <= 10; i++) begin
         drive(i, 0, i, 1);
         step();
      end
      drive(1, 2, 11, 1);
      #2;
      reset = 1'b1;
      #1;
      total++;
      if (ren_valid_o !== 1'b0 || ren_pd_o !== 6'd0) begin
         bad++;
         $display("FAIL midreset: got valid=%0b pd=%0d expected valid=0 pd=0", ren_valid_o, ren_pd_o);
      end
      fe_valid_i = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      drive(1, 2, 3, 1);
      step();
      total++;
      if (ren_ps1_o !== 6'd1 || ren_ps2_o !== 6'd2 || ren_pd_o !== 6'd32 || ren_old_pd_o !== 6'd3) begin
         bad++;
         $display("FAIL post_reset: got ps1=%0d ps2=%0d pd=%0d old=%0d expected 1 2 32 3",
                  ren_ps1_o, ren_ps2_o, ren_pd_o, ren_old_pd_o);
      end
      drive(7, 10, 8, 1);
      step();
      total++;
      if (ren_ps1_o !== 6'd7 || ren_ps2_o !== 6'd10 || ren_pd_o !== 6'd33 || ren_old_pd_o !== 6'd8) begin
         bad++;
         $display("FAIL post_reset_map: got ps1=%0d ps2=%0d pd=%0d old=%0d expected 7 10 33 8",
                  ren_ps1_o, ren_ps2_o, ren_pd_o, ren_old_pd_o);
      end
      fe_valid_i = 1'b0;
      step();
   endtask

   initial begin
      test_reset();
      test_first_and_dependent();
      test_no_alloc();
      test_back_to_back_exhaust();
      test_stall();
      test_reset_mid();
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
